dice_turn_fsm: RTL
==================

# dice_turn_fsm

Turn-sequencing game controller for the dice race. It sits directly downstream of the color detector and consumes `stable_color`, `result_ready` and `current_state_white`. It converts each accepted dice color into a step count and animates the active player's token one square per `step_tick`. Before handing the turn to the next player, it requires a clear white background.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players (2..4); turn order 0,1,..,NUM_PLAYERS-1, wraps to 0
- TRACK_LEN, 20, finish square; positions range 0..TRACK_LEN
- RED_STEPS, 1, squares moved for RED
- GREEN_STEPS, 2, squares moved for GREEN
- BLUE_STEPS, 3, squares moved for BLUE
- PW, $clog2(TRACK_LEN+1), position width (derived localparam, not overridable)

Ports:
- clk  in  1  system clock (pixel clock domain, same as the color detector)
- reset  in  1  asynchronous, active-high
- stable_color  in  2  00=NONE, 01=RED, 10=GREEN, 11=BLUE; sampled only with result_ready
- result_ready  in  1  single-cycle pulse: valid dice color
- current_state_white  in  1  level: white background currently detected
- step_tick  in  1  single-cycle pulse, one per animation step (frame-derived)
- game_restart  in  1  synchronous single-cycle restart request
- pos_flat  out  NUM_PLAYERS*PW  player i position at [i*PW +: PW]
- active_player  out  2  player whose turn it is
- moving  out  1  high while in MOVE
- last_color  out  2  color of the most recently accepted roll
- winner_valid  out  1  level: game over
- winner  out  2  winning player; valid only when winner_valid=1
- state_dbg  out  3  encoded current state

## Operation
States:
- WAIT_CLEAR: entered at reset and on restart. Advance only when current_state_white=1.
  - From reset or restart: go to WAIT_ROLL; active_player is unchanged.
  - After a move: active_player <= (active_player+1) mod NUM_PLAYERS, then go to WAIT_ROLL.
- WAIT_ROLL: on result_ready with stable_color≠00, load steps_left from the color map, latch last_color and go to MOVE.
  - result_ready with stable_color=00 is ignored.
- MOVE: on each step_tick, pos[active] += 1 and steps_left -= 1.
  - If the new pos equals TRACK_LEN: winner <= active_player, go to GAME_OVER; remaining steps are discarded.
  - Otherwise, if the new steps_left is 0: go to WAIT_CLEAR (after-move flag set).
- GAME_OVER: holds all outputs. Only reset or game_restart leaves this state.

Rules:
- result_ready is ignored in every state except WAIT_ROLL; there is no queuing.
- step_tick is ignored outside MOVE.
- A step_tick that arrives in the same cycle the FSM enters MOVE is not counted.
- Positions never exceed TRACK_LEN. steps_left is 2 bits wide, so each step parameter must be ≤3.
- game_restart has priority over every other event in the same cycle. It clears all positions, active_player, last_color and winner_valid, and enters WAIT_CLEAR with the after-move flag cleared.
- state_dbg encoding: WAIT_CLEAR=0, WAIT_ROLL=1, MOVE=2, GAME_OVER=3.

## Timing
- Reset values: all outputs 0; state WAIT_CLEAR, so state_dbg=0.
- result_ready at edge N (in WAIT_ROLL): moving=1 and last_color valid from N+1.
- step_tick at edge M (in MOVE): pos updated at M+1. The final step leaves MOVE at M+1, with moving=0 in the same cycle.
- WAIT_CLEAR with white=1 at edge K: active_player updated and state=WAIT_ROLL at K+1. A result_ready at K itself is ignored.
- Finish: winner_valid=1 and winner set in the same cycle that pos reaches TRACK_LEN.
- Restart at edge R: all cleared at R+1.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- `dice_race_pkg` holds:
  - `color_e` (NONE/RED/GREEN/BLUE, 2-bit), shared with the color detector
  - `turn_state_e` (the state encoding above)
  - function `color_steps(color_e)` implementing the step map
- No sub-module; this is a single FSM plus position register array and step counter. The step_tick generator lives outside this block.

## Test plan
- Reset, then white=1 for 1 cycle → WAIT_ROLL, player 0. RED pulse, then 1 step_tick → pos0=1, WAIT_CLEAR. White → active_player=1.
- BLUE roll with step_tick at 3 widely separated cycles → pos goes 1,2,3 exactly one cycle after each tick. A step_tick on the MOVE-entry cycle is not counted.
- result_ready during MOVE and during WAIT_CLEAR, and a NONE roll during WAIT_ROLL → no state or position change.
- Player 0 at pos 19 (TRACK_LEN=20) rolls BLUE → pos0=20 after 1 tick, winner_valid=1, winner=0. Further ticks and rolls change nothing.
- game_restart in the same cycle as step_tick in MOVE → all positions 0, state_dbg=0, player 0. Then white → WAIT_ROLL.
- NUM_PLAYERS=3: three full turns → active_player sequence 0,1,2,0.

Source files
------------

// File: rtl/dice_race_pkg.sv
// Shared types for the dice race game.
//   color_e       dice color code, shared with the color detector
//   turn_state_e  turn sequencer state encoding (also exported as state_dbg)
//   color_steps   maps an accepted dice color to a square count
package dice_race_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_BLUE  = 2'b11
  } color_e;

  typedef enum logic [2:0] {
    ST_WAIT_CLEAR = 3'd0,
    ST_WAIT_ROLL  = 3'd1,
    ST_MOVE       = 3'd2,
    ST_GAME_OVER  = 3'd3
  } turn_state_e;

  // Step counts are passed in so each instance can use its own map.
  function automatic logic [1:0] color_steps(input color_e     c,
                                             input logic [1:0] red_s,
                                             input logic [1:0] green_s,
                                             input logic [1:0] blue_s);
    logic [1:0] s;
    s = 2'd0;
    case (c)
      COLOR_RED:   s = red_s;
      COLOR_GREEN: s = green_s;
      COLOR_BLUE:  s = blue_s;
      default:     s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dice_turn_fsm.sv
// Turn sequencer for the dice race. Accepts a dice color, animates the
// active player's token one square per step_tick, then waits for a clear
// white background before handing the turn to the next player.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stable_color [1:0]    dice color, sampled only with result_ready
//   result_ready          single-cycle pulse: stable_color is valid
//   current_state_white   level: white background detected
//   step_tick             single-cycle pulse per animation step
//   game_restart          synchronous single-cycle restart request
//   pos_flat              player i position at [i*PW +: PW]
//   active_player [1:0]   player whose turn it is
//   moving                high while in MOVE
//   last_color [1:0]      most recently accepted roll
//   winner_valid, winner  game over flag and winning player
//   state_dbg [2:0]       current state encoding
module dice_turn_fsm
  import dice_race_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int TRACK_LEN   = 20,
  parameter int RED_STEPS   = 1,
  parameter int GREEN_STEPS = 2,
  parameter int BLUE_STEPS  = 3,
  localparam int PW         = $clog2(TRACK_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                stable_color,
  input  logic                      result_ready,
  input  logic                      current_state_white,
  input  logic                      step_tick,
  input  logic                      game_restart,
  output logic [NUM_PLAYERS*PW-1:0] pos_flat,
  output logic [1:0]                active_player,
  output logic                      moving,
  output logic [1:0]                last_color,
  output logic                      winner_valid,
  output logic [1:0]                winner,
  output logic [2:0]                state_dbg
);

  // Handshake: result_ready is a valid-only pulse with no back-pressure.
  // It is consumed only in WAIT_ROLL with a non-NONE color; in every other
  // case the roll is dropped, never queued.

  turn_state_e state_q, state_d;
  logic        after_move_q, after_move_d;
  logic [1:0]  player_q, player_d;
  color_e      last_q, last_d;
  logic        winv_q, winv_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  steps_q, steps_d;
  logic [PW-1:0] pos_q [NUM_PLAYERS];
  logic [PW-1:0] pos_d [NUM_PLAYERS];

  logic [PW-1:0] cur_pos;
  logic [PW-1:0] new_pos;
  logic [1:0]    new_steps;
  logic [1:0]    next_player;

  always_comb begin
    state_d      = state_q;
    after_move_d = after_move_q;
    player_d     = player_q;
    last_d       = last_q;
    winv_d       = winv_q;
    winner_d     = winner_q;
    steps_d      = steps_q;
    for (int i = 0; i < NUM_PLAYERS; i++) pos_d[i] = pos_q[i];

    cur_pos = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (player_q == 2'(i)) cur_pos = pos_q[i];
    new_pos     = cur_pos + PW'(1);
    new_steps   = steps_q - 2'd1;
    next_player = (player_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : player_q + 2'd1;

    if (game_restart) begin
      state_d      = ST_WAIT_CLEAR;
      after_move_d = 1'b0;
      player_d     = 2'd0;
      last_d       = COLOR_NONE;
      winv_d       = 1'b0;
      winner_d     = 2'd0;
      steps_d      = 2'd0;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_d[i] = '0;
    end else begin
      case (state_q)
        ST_WAIT_CLEAR: begin
          if (current_state_white) begin
            // Turn only passes on after a completed move, not after restart.
            if (after_move_q) player_d = next_player;
            after_move_d = 1'b0;
            state_d      = ST_WAIT_ROLL;
          end
        end
        ST_WAIT_ROLL: begin
          if (result_ready && (stable_color != COLOR_NONE)) begin
            steps_d = color_steps(color_e'(stable_color), 2'(RED_STEPS),
                                  2'(GREEN_STEPS), 2'(BLUE_STEPS));
            last_d  = color_e'(stable_color);
            state_d = ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (step_tick) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (player_q == 2'(i)) pos_d[i] = new_pos;
            steps_d = new_steps;
            // Reaching the finish ends the game; leftover steps are dropped.
            if (new_pos == PW'(TRACK_LEN)) begin
              winv_d   = 1'b1;
              winner_d = player_q;
              state_d  = ST_GAME_OVER;
            end else if (new_steps == 2'd0) begin
              after_move_d = 1'b1;
              state_d      = ST_WAIT_CLEAR;
            end
          end
        end
        ST_GAME_OVER: begin
        end
        default: state_d = ST_WAIT_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_CLEAR;
      after_move_q <= 1'b0;
      player_q     <= 2'd0;
      last_q       <= COLOR_NONE;
      winv_q       <= 1'b0;
      winner_q     <= 2'd0;
      steps_q      <= 2'd0;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      after_move_q <= after_move_d;
      player_q     <= player_d;
      last_q       <= last_d;
      winv_q       <= winv_d;
      winner_q     <= winner_d;
      steps_q      <= steps_d;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= pos_d[i];
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pos
    assign pos_flat[g*PW +: PW] = pos_q[g];
  end

  assign active_player = player_q;
  assign moving        = (state_q == ST_MOVE);
  assign last_color    = last_q;
  assign winner_valid  = winv_q;
  assign winner        = winner_q;
  assign state_dbg     = state_q;

endmodule
